// File: rtl/uart_prog_loader.sv
// ----------------------------------------------------------------------------
// uart_prog_loader
//   Pulls a program image out of the 32-bit UART word receiver. It requests
//   one word at a time. The first word is a length N. The next N words are
//   written to consecutive instruction-memory addresses, starting at
//   BASE_ADDR. Completion and error are reported to the boot logic.
//
//   Optional feature (macro UART_LOADER_CHECKSUM_EN):
//     After the last data word, one more word is requested. It is compared
//     with a running XOR of the data words, and a mismatch sets err.
//
// Ports
//   clk, rstn    clock and asynchronous active-low reset
//   start        begin a load (honoured only in IDLE or DONE)
//   rx_data      word from receiver
//   rx_valid     one-cycle pulse, rx_data valid
//   rx_req       one-cycle pulse, request next word
//   mem_we       one-cycle write strobe per data word
//   mem_addr     write address (holds when mem_we=0)
//   mem_wdata    write data (holds when mem_we=0)
//   busy         high while a load is in progress
//   done         high in DONE, cleared by start
//   err          bad length (or checksum mismatch), valid while done=1
//   words_left   remaining data words (debug)
// ----------------------------------------------------------------------------
module uart_prog_loader #(
    parameter int unsigned           ADDR_W    = 14,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0,
    parameter int unsigned           MAX_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [31:0]       rx_data,
    input  logic              rx_valid,
    output logic              rx_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       words_left
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ_LEN,
        S_WAIT_LEN,
        S_REQ_DATA,
        S_WAIT_DATA,
        S_WRITE,
        S_DONE
`ifdef UART_LOADER_CHECKSUM_EN
        ,
        S_REQ_SUM,
        S_WAIT_SUM
`endif
    } state_t;

    state_t            state_q, state_d;
    logic              rx_req_q, rx_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       words_left_q, words_left_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        err_d        = err_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
`ifdef UART_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_REQ_LEN;
                    err_d   = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_REQ_LEN:  state_d = S_WAIT_LEN;
            S_WAIT_LEN: begin
                if (rx_valid) begin
                    // Full 32-bit compare: huge lengths must not alias into range.
                    if (rx_data == 32'd0 || rx_data > 32'(MAX_WORDS)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        words_left_d = rx_data;
                        addr_d       = BASE_ADDR;
                        state_d      = S_REQ_DATA;
                    end
                end
            end
            S_REQ_DATA:  state_d = S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (rx_valid) begin
                    mem_wdata_d = rx_data;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d       = sum_q ^ rx_data;
`endif
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address wraps modulo 2^ADDR_W by truncation.
                addr_d       = addr_q + ADDR_W'(1);
                words_left_d = words_left_q - 32'd1;
                if (words_left_q == 32'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                    state_d = S_REQ_SUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_REQ_DATA;
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            S_REQ_SUM:  state_d = S_WAIT_SUM;
            S_WAIT_SUM: begin
                if (rx_valid) begin
                    if (rx_data != sum_q) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies decoded from the next state, so they
        // line up with the state they belong to.
        rx_req_d = (state_d == S_REQ_LEN) || (state_d == S_REQ_DATA);
`ifdef UART_LOADER_CHECKSUM_EN
        rx_req_d = rx_req_d || (state_d == S_REQ_SUM);
`endif
        mem_we_d = (state_d == S_WRITE);
        if (state_d == S_WRITE) mem_addr_d = addr_q;
        busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            rx_req_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            words_left_q <= '0;
            addr_q       <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rx_req_q     <= rx_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign rx_req     = rx_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_left = words_left_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader. Two instances share the stimulus. One uses
// BASE_ADDR=0 and the other uses BASE_ADDR=2^14-1, so that the wrap case is
// exercised. A protocol-level model predicts every output on every cycle.
// Directed loads also check literal write logs and pulse counts.
module tb_uart_prog_loader;
    localparam int          AW    = 14;
    localparam logic [31:0] MAXW  = 32'd16384;
    localparam logic [AW-1:0] WBASE = 14'h3FFF;

    logic clk = 1'b0;
    logic rstn, start, rx_valid;
    logic [31:0] rx_data;
    logic rx_req, mem_we, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata, words_left;
    logic w_rx_req, w_mem_we, w_busy, w_done, w_err;
    logic [AW-1:0] w_mem_addr;
    logic [31:0] w_mem_wdata, w_words_left;

    int n_tests = 0, n_fail = 0;
    int n_req = 0, n_we = 0;
    logic [AW-1:0] wa [16];
    logic [AW-1:0] wwa [16];
    logic [31:0]   wd [16];
    logic [31:0]   dat [8];
    logic [31:0]   host_q [$];
    bit stray_arm = 1'b0;

    always #5 clk = ~clk;

    uart_prog_loader #(.ADDR_W(AW), .BASE_ADDR(14'd0), .MAX_WORDS(16384)) dut (
        .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_req(rx_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .words_left(words_left));

    uart_prog_loader #(.ADDR_W(AW), .BASE_ADDR(WBASE), .MAX_WORDS(16384)) dut_w (
        .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_req(w_rx_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .busy(w_busy), .done(w_done), .err(w_err), .words_left(w_words_left));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks which reply the loader is listening for, and when the
    // next request and write are due. It records the output values that should
    // be visible after each clock edge.
    localparam int K_NONE = 0, K_LEN = 1, K_DATA = 2, K_SUM = 3;
    bit          m_busy, m_done, m_err, m_req, m_we, m_wrote;
    int          m_wait, m_next, m_off, m_woff;
    logic [31:0] m_left, m_wdata, m_xor;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 0; m_done = 0; m_err = 0; m_req = 0; m_we = 0; m_wrote = 0;
            m_wait = K_NONE; m_next = K_NONE; m_off = 0; m_woff = 0;
            m_left = 0; m_wdata = 0; m_xor = 0;
        end else begin
            bit prev_req, prev_we;
            int listen;
            prev_req = m_req; prev_we = m_we; listen = m_wait;
            m_req = 0; m_we = 0;
            // A reply is only heard from the cycle after its request pulse.
            if (prev_req) m_wait = m_next;
            if (start && !m_busy) begin
                m_busy = 1; m_done = 0; m_err = 0; m_xor = 0;
                m_req = 1; m_next = K_LEN;
            end else if (listen != K_NONE && rx_valid) begin
                m_wait = K_NONE;
                if (listen == K_LEN) begin
                    if (rx_data == 0 || rx_data > MAXW) begin
                        m_err = 1; m_busy = 0; m_done = 1;
                    end else begin
                        m_left = rx_data; m_off = 0; m_req = 1; m_next = K_DATA;
                    end
                end else if (listen == K_DATA) begin
                    m_we = 1; m_wdata = rx_data; m_woff = m_off; m_wrote = 1;
                    m_xor = m_xor ^ rx_data;
                end else begin
                    m_err = (rx_data != m_xor); m_busy = 0; m_done = 1;
                end
            end else if (prev_we) begin
                m_off++; m_left = m_left - 1;
                if (m_left == 0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                    m_req = 1; m_next = K_SUM;
`else
                    m_busy = 0; m_done = 1;
`endif
                end else begin
                    m_req = 1; m_next = K_DATA;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        logic [AW-1:0] ea, ewa;
        ea  = m_wrote ? AW'(m_woff) : '0;
        ewa = m_wrote ? AW'(WBASE + AW'(m_woff)) : '0;
        chk("cyc rx_req", 32'(rx_req), 32'(m_req));
        chk("cyc mem_we", 32'(mem_we), 32'(m_we));
        chk("cyc mem_addr", 32'(mem_addr), 32'(ea));
        chk("cyc mem_wdata", mem_wdata, m_wdata);
        chk("cyc busy", 32'(busy), 32'(m_busy));
        chk("cyc done", 32'(done), 32'(m_done));
        chk("cyc err", 32'(err), 32'(m_err));
        chk("cyc words_left", words_left, m_left);
        chk("cyc w rx_req", 32'(w_rx_req), 32'(m_req));
        chk("cyc w mem_we", 32'(w_mem_we), 32'(m_we));
        chk("cyc w mem_addr", 32'(w_mem_addr), 32'(ewa));
        chk("cyc w mem_wdata", w_mem_wdata, m_wdata);
        chk("cyc w busy/done/err", {29'd0, w_busy, w_done, w_err}, {29'd0, m_busy, m_done, m_err});
        chk("cyc w words_left", w_words_left, m_left);
    end

    // Pulse counters and write log.
    always @(negedge clk) begin
        if (rx_req) n_req++;
        if (mem_we && n_we < 16) begin
            wa[n_we] = mem_addr; wwa[n_we] = w_mem_addr; wd[n_we] = mem_wdata;
        end
        if (mem_we) n_we++;
    end

    // Host: answers each rx_req with the next queued word, one cycle later.
    initial begin
        logic [31:0] w;
        bit pend, mine;
        pend = 0; mine = 0; w = 0;
        forever begin
            @(negedge clk);
            if (pend) begin rx_data = w; rx_valid = 1; pend = 0; mine = 1; end
            else if (mine) begin rx_valid = 0; mine = 0; end
            if (rx_req && host_q.size() > 0) begin w = host_q.pop_front(); pend = 1; end
        end
    end

    // Stray rx_valid injected during a WRITE cycle, offset from the host's edge.
    initial begin
        forever begin
            @(negedge clk);
            if (stray_arm && mem_we) begin
                stray_arm = 0;
                #2; rx_data = 32'hDEADBEEF; rx_valid = 1;
                @(negedge clk); #2; rx_valid = 0;
            end
        end
    end

    task automatic stray();
        rx_data = 32'hDEADBEEF; rx_valid = 1;
        @(negedge clk); rx_valid = 0;
    endtask

    task automatic load(input string nm, input logic [31:0] len, input int n,
                        input bit use_sum, input logic [31:0] sumw, input bit exp_err);
        logic [31:0] x;
        int ereq;
        x = 0;
        host_q.delete(); host_q.push_back(len);
        for (int i = 0; i < n; i++) begin host_q.push_back(dat[i]); x = x ^ dat[i]; end
        x = use_sum ? sumw : x;
        ereq = (n == 0) ? 1 : n + 1;
`ifdef UART_LOADER_CHECKSUM_EN
        if (n > 0) begin host_q.push_back(x); ereq++; end
`endif
        n_req = 0; n_we = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        chk({nm, " busy after start"}, 32'(busy), 32'd1);
        chk({nm, " done cleared by start"}, 32'(done), 32'd0);
        chk({nm, " err cleared by start"}, 32'(err), 32'd0);
        for (int c = 0; c < 400 && done !== 1'b1; c++) @(negedge clk);
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " err"}, 32'(err), 32'(exp_err));
        chk({nm, " busy at end"}, 32'(busy), 32'd0);
        chk({nm, " rx_req pulses"}, 32'(n_req), 32'(ereq));
        chk({nm, " mem_we pulses"}, 32'(n_we), 32'(n));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 0; start = 0; rx_valid = 0; rx_data = 0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {25'd0, rx_req, mem_we, busy, done, err, |mem_addr, |mem_wdata}, 32'd0);
        chk("reset words_left", words_left, 32'd0);
        rstn = 1;
        repeat (2) @(negedge clk);

        // stray in IDLE
        n_we = 0;
        stray();
        repeat (2) @(negedge clk);
        chk("idle stray busy", 32'(busy), 32'd0);
        chk("idle stray writes", 32'(n_we), 32'd0);

        // normal load with a stray rx_valid during WRITE
        dat[0] = 32'h11111111; dat[1] = 32'h22222222; dat[2] = 32'h33333333;
        stray_arm = 1;
        load("normal", 32'd3, 3, 0, 32'd0, 0);
        chk("normal stray consumed", 32'(stray_arm), 32'd0);
        chk("normal addr0", 32'(wa[0]), 32'd0);
        chk("normal addr1", 32'(wa[1]), 32'd1);
        chk("normal addr2", 32'(wa[2]), 32'd2);
        chk("normal data0", wd[0], 32'h11111111);
        chk("normal data1", wd[1], 32'h22222222);
        chk("normal data2", wd[2], 32'h33333333);
        chk("normal wrap-inst addr0", 32'(wwa[0]), 32'd16383);
        chk("normal wrap-inst addr1", 32'(wwa[1]), 32'd0);
        chk("normal words_left", words_left, 32'd0);

        // stray in DONE
        stray();
        repeat (2) @(negedge clk);
        chk("done stray done", 32'(done), 32'd1);
        chk("done stray writes", 32'(n_we), 32'd3);

        // bad lengths
        load("len0", 32'd0, 0, 0, 32'd0, 1);
        load("len16385", 32'd16385, 0, 0, 32'd0, 1);
        load("lenhuge", 32'h80000001, 0, 0, 32'd0, 1);

        // reset mid-load after 2 of 5 writes
        for (int i = 0; i < 5; i++) dat[i] = 32'hBEEF0000 + i;
        host_q.delete(); host_q.push_back(32'd5);
        for (int i = 0; i < 5; i++) host_q.push_back(dat[i]);
        n_we = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int c = 0; c < 200 && n_we < 2; c++) @(negedge clk);
        chk("midload writes before reset", 32'(n_we), 32'd2);
        rstn = 0;
        @(negedge clk);
        chk("midload reset outputs", {25'd0, rx_req, mem_we, busy, done, err, |mem_addr, |mem_wdata}, 32'd0);
        chk("midload reset words_left", words_left, 32'd0);
        @(negedge clk);
        host_q.delete();
        rstn = 1;
        repeat (3) @(negedge clk);

        // fresh start, wrap on the high-base instance
        dat[0] = 32'hCAFE0001; dat[1] = 32'hCAFE0002;
        load("wrap", 32'd2, 2, 0, 32'd0, 0);
        chk("wrap addr0", 32'(wwa[0]), 32'd16383);
        chk("wrap addr1", 32'(wwa[1]), 32'd0);
        chk("wrap data1", wd[1], 32'hCAFE0002);

        // restart from DONE
        dat[0] = 32'h12345678;
        load("restart", 32'd1, 1, 0, 32'd0, 0);
        chk("restart data", wd[0], 32'h12345678);
        chk("restart addr", 32'(wa[0]), 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
        dat[0] = 32'hA5A5A5A5; dat[1] = 32'h0F0F0F0F;
        load("sum good", 32'd2, 2, 1, 32'hAAAAAAAA, 0);
        load("sum bad", 32'd2, 2, 1, 32'hAAAAAAAB, 1);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
